// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and sizing helpers for the sync_fifo_ctrl family
package fifo_pkg;

  typedef enum logic {
    RD_STANDARD = 1'b0,
    RD_FWFT     = 1'b1
  } read_mode_e;

  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEFAULT_DEPTH      = 1 << DEFAULT_ADDR_WIDTH;
  localparam int DEFAULT_COUNT_W    = DEFAULT_ADDR_WIDTH + 1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  function automatic int count_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// rtl/fifo_ptr_ctrl.sv - pointers, fill count, accept logic and level flags
// Sticky overflow/underflow registers exist only when FIFO_ERR_FLAGS_EN is defined.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_write_enable,
  input  logic                  i_read_enable,
  output logic                  o_push,
  output logic                  o_pop,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_full,
  output logic                  o_empty,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CW    = count_width(ADDR_WIDTH);
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_THRESH);
  localparam logic [CW-1:0] C_AE    = CW'(AE_THRESH);

  if (AE_THRESH >= AF_THRESH || AF_THRESH < 1 || AF_THRESH > DEPTH ||
      AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_thresh
    $error("fifo_ptr_ctrl: illegal AF_THRESH/AE_THRESH combination");
  end

  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  // All flags come from the registered count, so they lag the causing edge by one cycle.
  assign o_full         = (r_count == C_DEPTH);
  assign o_empty        = (r_count == '0);
  assign o_almost_full  = (r_count >= C_AF);
  assign o_almost_empty = (r_count <= C_AE);
  assign o_count        = r_count;

  assign w_push    = i_write_enable && !o_full;
  assign w_pop     = i_read_enable && !o_empty;
  assign o_push    = w_push;
  assign o_pop     = w_pop;
  assign o_wr_addr = r_wr_ptr[ADDR_WIDTH-1:0];
  assign o_rd_addr = r_rd_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (i_write_enable && o_full) r_overflow  <= 1'b1;
      if (i_read_enable && o_empty) r_underflow <= 1'b1;
    end
  end

  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;
`else
  assign o_overflow  = 1'b0;
  assign o_underflow = 1'b0;
`endif

endmodule

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with level flags, standard or FWFT read
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic                  w_push;
  logic                  w_pop;
  logic [ADDR_WIDTH-1:0] w_wr_addr;
  logic [ADDR_WIDTH-1:0] w_rd_addr;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  fifo_ptr_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .AF_THRESH  (AF_THRESH),
    .AE_THRESH  (AE_THRESH)
  ) u_ptr (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_write_enable (write_enable),
    .i_read_enable  (read_enable),
    .o_push         (w_push),
    .o_pop          (w_pop),
    .o_wr_addr      (w_wr_addr),
    .o_rd_addr      (w_rd_addr),
    .o_full         (full),
    .o_empty        (empty),
    .o_almost_full  (almost_full),
    .o_almost_empty (almost_empty),
    .o_count        (count),
    .o_overflow     (overflow),
    .o_underflow    (underflow)
  );

  // Storage is deliberately not reset; reset only discards contents via the pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[w_wr_addr] <= write_data;
  end

  if (FWFT == int'(RD_FWFT)) begin : g_fwft
    assign read_data = r_mem[w_rd_addr];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] r_read_data;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)        r_read_data <= '0;
      else if (w_pop) r_read_data <= r_mem[w_rd_addr];
    end

    assign read_data = r_read_data;
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - scoreboard bench for standard and FWFT sync_fifo_ctrl instances
module tb_sync_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we  = 1'b0;
  logic          re  = 1'b0;
  logic [DW-1:0] wd  = '0;

  logic [DW-1:0] s_rd, f_rd;
  logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [AW:0]   s_cnt, f_cnt;

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AF_THRESH(AF), .AE_THRESH(AE)) u_std (
    .clk(clk), .rst(rst), .write_enable(we), .write_data(wd), .read_enable(re),
    .read_data(s_rd), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_cnt), .overflow(s_ovf), .underflow(s_unf)
  );

  sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AF_THRESH(AF), .AE_THRESH(AE)) u_fwft (
    .clk(clk), .rst(rst), .write_enable(we), .write_data(wd), .read_enable(re),
    .read_data(f_rd), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_cnt), .overflow(f_ovf), .underflow(f_unf)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_rd = '0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_ovf();
`ifdef FIFO_ERR_FLAGS_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit exp_unf();
`ifdef FIFO_ERR_FLAGS_EN
    return m_unf;
`else
    return 1'b0;
`endif
  endfunction

  // One clock of stimulus; the reference queue is advanced from the pre-edge occupancy.
  task automatic cycle(input bit w, input logic [DW-1:0] d, input bit r);
    int n;
    we = w;
    wd = d;
    re = r;
    @(posedge clk);
    n = model_q.size();
    if (w && n == DEPTH) m_ovf = 1'b1;
    if (r && n == 0)     m_unf = 1'b1;
    if (r && n > 0)      exp_q.push_back(model_q.pop_front());
    if (w && n < DEPTH)  model_q.push_back(d);
    #1;
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_async_std_count", 32'(s_cnt), 0);
    check("rst_async_std_empty", 32'(s_empty), 1);
    check("rst_async_fwft_count", 32'(f_cnt), 0);
    check("rst_async_fwft_empty", 32'(f_empty), 1);
    check("rst_async_std_ovf", 32'(s_ovf), 0);
    check("rst_async_std_unf", 32'(s_unf), 0);
    model_q.delete();
    exp_q.delete();
    last_rd = '0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Monitor: compares both instances against the reference queue away from the active edge.
  always @(negedge clk) begin
    int n;
    n = model_q.size();
    if (exp_q.size() > 0) last_rd = exp_q.pop_front();
    check("std_read_data", 32'(s_rd), 32'(last_rd));
    check("std_count", 32'(s_cnt), n);
    check("std_full", 32'(s_full), 32'(n == DEPTH));
    check("std_empty", 32'(s_empty), 32'(n == 0));
    check("std_almost_full", 32'(s_af), 32'(n >= AF));
    check("std_almost_empty", 32'(s_ae), 32'(n <= AE));
    check("std_overflow", 32'(s_ovf), 32'(exp_ovf()));
    check("std_underflow", 32'(s_unf), 32'(exp_unf()));
    check("fwft_count", 32'(f_cnt), n);
    check("fwft_full", 32'(f_full), 32'(n == DEPTH));
    check("fwft_empty", 32'(f_empty), 32'(n == 0));
    check("fwft_almost_full", 32'(f_af), 32'(n >= AF));
    check("fwft_almost_empty", 32'(f_ae), 32'(n <= AE));
    check("fwft_overflow", 32'(f_ovf), 32'(exp_ovf()));
    check("fwft_underflow", 32'(f_unf), 32'(exp_unf()));
    if (n > 0) check("fwft_read_data", 32'(f_rd), 32'(model_q[0]));
  end

  initial begin
    #1 rst = 1'b1;
    #1;
    check("reset_count", 32'(s_cnt), 0);
    check("reset_empty", 32'(s_empty), 1);
    check("reset_almost_empty", 32'(s_ae), 1);
    check("reset_full", 32'(s_full), 0);
    check("reset_almost_full", 32'(s_af), 0);
    check("reset_read_data", 32'(s_rd), 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fill to full, then one push that must be dropped.
    cycle(1, 8'h11, 0);
    cycle(1, 8'h22, 0);
    cycle(1, 8'h33, 0);
    cycle(1, 8'h44, 0);
    cycle(1, 8'h55, 0);
    cycle(0, 8'h00, 0);

    // Drain four words plus one rejected pop.
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);

    // Single word into an empty FIFO, then pop it.
    cycle(1, 8'hA5, 0);
    cycle(0, 8'h00, 0);
    cycle(0, 8'h00, 1);
    cycle(0, 8'h00, 0);

    // Push and pop together at count 2 across several pointer wraps.
    cycle(1, 8'h01, 0);
    cycle(1, 8'h02, 0);
    for (int i = 0; i < 10; i++) cycle(1, 8'(8'h03 + i), 1);

    // Push and pop together while full: only the pop may be accepted.
    cycle(1, 8'h20, 0);
    cycle(1, 8'h21, 0);
    cycle(1, 8'h77, 1);
    for (int i = 0; i < 5; i++) cycle(0, 8'h00, 1);

    // Randomised traffic with an asynchronous reset in the middle of a burst.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        cycle(1, 8'(i), 1);
        async_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 2) == 0);
      end
      if (i % 97 == 0) for (int k = 0; k < 6; k++) cycle(0, 8'h00, 1);
    end

    cycle(0, 8'h00, 0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ctrl.md
Name: sync_fifo_ctrl

Overview:
Parametrised single-clock FIFO. It is the next generation of the team's pointer/compare FIFO, adding:
- a fill-level counter;
- programmable almost-full and almost-empty thresholds;
- a selectable standard or first-word-fall-through (FWFT) read mode;
- optional sticky overflow/underflow flags.

It sits between a producer and a consumer in the same clock domain. The storage array is internal.

Parameters:
DATA_WIDTH, 8, width of a stored word
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (range 1..DEPTH)
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (range 0..DEPTH-1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
write_enable  in  1  push request
write_data  in  DATA_WIDTH  push data
read_enable  in  1  pop request
read_data  out  DATA_WIDTH  pop data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  ADDR_WIDTH+1  words stored
overflow  out  1  sticky; only with FIFO_ERR_FLAGS_EN
underflow  out  1  sticky; only with FIFO_ERR_FLAGS_EN

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - write and read pointers = 0, count = 0;
  - empty = 1, almost_empty = 1;
  - full = 0, almost_full = 0 (AF_THRESH >= 1);
  - read_data = 0, overflow = 0, underflow = 0.
  - Reset asserted mid-operation discards all contents immediately. The storage array itself is not cleared.
- Pointers: ADDR_WIDTH+1 bits. The low ADDR_WIDTH bits index storage; the MSB is the wrap bit, so pointers wrap from DEPTH-1 to 0 with the MSB toggling.
- Accept rules:
  - A push is accepted when write_enable && !full.
  - A pop is accepted when read_enable && !empty.
  - Flags are sampled pre-edge. A push while full is dropped even if a pop is accepted in the same cycle.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither. It is registered.
- Flag timing: all flags are decoded from registered count, so they are valid the cycle after the causing edge.
- Standard mode (FWFT=0):
  - read_data is registered and updates on the edge that accepts a pop, i.e. data is valid one cycle after read_enable.
  - read_data holds its last value otherwise, including on a rejected pop.
- FWFT mode (FWFT=1):
  - read_data combinationally shows storage[rd_ptr] whenever !empty. A pop advances to the next word.
  - The first write into an empty FIFO becomes visible the cycle after the write edge, when empty deasserts.
  - read_data is don't-care while empty.
- Simultaneous push and pop:
  - On an empty FIFO, only the push is accepted.
  - On a full FIFO, only the pop is accepted.
  - Otherwise both are accepted.
- Read-during-write to the same address cannot occur, because empty blocks the pop.
- Elaboration-time check: assertion if AE_THRESH >= AF_THRESH or either threshold is out of range.

Optional Feature:
FIFO_ERR_FLAGS_EN
- Defined:
  - overflow sets on write_enable && full; underflow sets on read_enable && empty.
  - Both are sticky until rst.
  - They set on the same edge as the rejected request and are visible the next cycle.
- Undefined: both ports are tied to 0 and no flag registers are generated. The port list is unchanged.

Decomposition:
- Package fifo_pkg:
  - function clog2;
  - localparam helpers for DEPTH and count width;
  - typedef read_mode_e {RD_STANDARD, RD_FWFT}.
- One natural sub-module, fifo_ptr_ctrl. It holds pointer and count registers, accept logic, and flag decode, and is reused by later async variants.
- Storage and the read_data path stay in the top module.

Test Plan:
- Reset and fill (ADDR_WIDTH=2, AF_THRESH=3, AE_THRESH=1):
  - After rst: empty=1, almost_empty=1, count=0.
  - Push 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_empty drops at count=2; almost_full rises at count=3; full=1 at 4.
  - Fifth push 0x55 ignored, count stays 4.
- Standard drain: pop 4x -> read_data 0x11,0x22,0x33,0x44, each one cycle after its read_enable; empty=1 after the 4th. A fifth pop leaves read_data=0x44.
- FWFT=1: push 0xA5 into empty -> next cycle empty=0 and read_data=0xA5 with no pop; pop -> empty=1.
- Simultaneous: at count=2 assert push+pop for 10 cycles with incrementing data -> count stays 2 and output order is preserved across pointer wrap (≥2 wraps).
- Full+both: at count=4 assert push(0x77)+pop -> pop accepted, push dropped, count=3; 0x77 never appears at output.
- FIFO_ERR_FLAGS_EN defined: push while full -> overflow=1 next cycle and holds; pop while empty -> underflow=1. Async rst mid-burst clears both flags, count=0 and empty=1 immediately, without waiting for a clock edge.
